// File: rtl/wbp_rx_buffer.sv
// -----------------------------------------------------------------------------
// wbp_rx_buffer
//   Receive-side packet FIFO between an endpoint sink and the fabric mux.
//   Every accepted sink word is stored as {eof, adr, sel, dat}. When the sink
//   frame closes, an eof marker is stored behind the last word. A source FSM
//   replays the words as one pipelined fabric cycle per packet. It waits for
//   all outstanding acknowledges, then drops cyc for a single cycle between
//   frames.
//
//   Optional feature: define WBP_RX_BUFFER_ERR_EN so that a downstream
//   src_err_i aborts the frame. The rest of the packet is then flushed up to
//   and including its marker. Without the macro, src_err_i is ignored.
//
// Parameters
//   g_size_log2    : FIFO depth is 2**g_size_log2 entries
//   g_stall_margin : sink stalls while free entries < g_stall_margin
//
// Ports
//   clk_sys_i, rst_n_i        : clock, asynchronous active-high reset
//   snk_*                     : pipelined fabric sink (from endpoint)
//   src_*                     : pipelined fabric source (toward wbp_mux)
//   usedw_o                   : current FIFO occupancy
// -----------------------------------------------------------------------------
module wbp_rx_buffer #(
  parameter int g_size_log2    = 6,
  parameter int g_stall_margin = 2
) (
  input  logic                   clk_sys_i,
  input  logic                   rst_n_i,
  input  logic [1:0]             snk_adr_i,
  input  logic [15:0]            snk_dat_i,
  input  logic [1:0]             snk_sel_i,
  input  logic                   snk_cyc_i,
  input  logic                   snk_stb_i,
  output logic                   snk_ack_o,
  output logic                   snk_err_o,
  output logic                   snk_stall_o,
  output logic [1:0]             src_adr_o,
  output logic [15:0]            src_dat_o,
  output logic [1:0]             src_sel_o,
  output logic                   src_cyc_o,
  output logic                   src_stb_o,
  output logic                   src_we_o,
  input  logic                   src_ack_i,
  input  logic                   src_err_i,
  input  logic                   src_stall_i,
  output logic [g_size_log2:0]   usedw_o
);

  localparam int c_depth = 2 ** g_size_log2;
  // Occupancy above which fewer than g_stall_margin entries remain free.
  localparam logic [g_size_log2:0]   c_stall_lvl = (g_size_log2 + 1)'(c_depth - g_stall_margin);
  localparam logic [g_size_log2:0]   c_cnt_one   = (g_size_log2 + 1)'(1);
  localparam logic [g_size_log2-1:0] c_ptr_one   = g_size_log2'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STREAM = 3'd1,
    S_FLUSH  = 3'd2,
    S_DRAIN  = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  logic [20:0]            mem_r [c_depth];
  logic [g_size_log2-1:0] wr_ptr_r;
  logic [g_size_log2-1:0] rd_ptr_r;
  logic [g_size_log2:0]   usedw_r;
  logic [g_size_log2:0]   usedw_next_s;
  logic                   cyc_d_r;
  logic                   sync_r;
  logic                   ack_r;
  logic                   stall_r;
  logic [15:0]            outst_r;
  logic [15:0]            outst_next_s;
  state_t                 state_r;
  logic                   src_cyc_r;

  logic                   acc_s;
  logic                   push_word_s;
  logic                   push_eof_s;
  logic                   push_s;
  logic [20:0]            wr_data_s;
  logic [20:0]            head_s;
  logic                   head_valid_s;
  logic                   head_eof_s;
  logic                   pop_s;
  logic                   stb_s;
  logic                   issue_s;

  // sync_r stays low after reset until the sink frame has been seen low once.
  // The tail of a packet cut by reset is then acknowledged but not stored, and
  // it gets no marker.
  assign acc_s       = snk_cyc_i & snk_stb_i & ~stall_r;
  assign push_word_s = acc_s & sync_r;
  assign push_eof_s  = cyc_d_r & ~snk_cyc_i & sync_r;
  assign push_s      = push_word_s | push_eof_s;
  assign wr_data_s   = push_eof_s ? 21'h10_0000 : {1'b0, snk_adr_i, snk_sel_i, snk_dat_i};

  assign head_s       = mem_r[rd_ptr_r];
  assign head_valid_s = (usedw_r != '0);
  assign head_eof_s   = head_s[20];
  assign issue_s      = stb_s & ~src_stall_i;

  // Source-side pop and strobe decode from the current state and FIFO head.
  always_comb begin
    pop_s = 1'b0;
    stb_s = 1'b0;
    case (state_r)
      S_IDLE:   pop_s = head_valid_s & head_eof_s;  // empty packet vanishes
      S_STREAM: begin
        stb_s = head_valid_s & ~head_eof_s;
        if (head_valid_s & head_eof_s) begin
          pop_s = 1'b1;
        end else begin
          pop_s = stb_s & ~src_stall_i;
        end
      end
      S_FLUSH:  pop_s = head_valid_s;
      default:  pop_s = 1'b0;
    endcase
  end

  // Next occupancy; a simultaneous push and pop cancel.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   usedw_next_s = usedw_r + c_cnt_one;
      2'b01:   usedw_next_s = usedw_r - c_cnt_one;
      default: usedw_next_s = usedw_r;
    endcase
  end

  // Outstanding-strobe count; an issue and an ack in the same cycle cancel.
  always_comb begin
    if (state_r == S_FLUSH) begin
      outst_next_s = 16'd0;
    end else if (issue_s & ~src_ack_i) begin
      outst_next_s = outst_r + 16'd1;
    end else if (~issue_s & src_ack_i & (outst_r != 16'd0)) begin
      outst_next_s = outst_r - 16'd1;
    end else begin
      outst_next_s = outst_r;
    end
  end

  // Entry storage. It has no reset because the pointers qualify its contents.
  always_ff @(posedge clk_sys_i) begin
    if (push_s) mem_r[wr_ptr_r] <= wr_data_s;
  end

  // Pointers, occupancy, counter and the registered sink handshake.
  always_ff @(posedge clk_sys_i or posedge rst_n_i) begin
    if (rst_n_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      usedw_r  <= '0;
      outst_r  <= 16'd0;
      cyc_d_r  <= 1'b0;
      sync_r   <= 1'b0;
      ack_r    <= 1'b0;
      stall_r  <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + c_ptr_one;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + c_ptr_one;
      usedw_r <= usedw_next_s;
      outst_r <= outst_next_s;
      cyc_d_r <= snk_cyc_i;
      sync_r  <= sync_r | ~snk_cyc_i;
      ack_r   <= acc_s;
      // Stall follows the occupancy it will sit beside. A word accepted now
      // therefore always leaves room for the marker.
      stall_r <= (usedw_next_s > c_stall_lvl);
    end
  end

  // Source frame FSM with registered cyc.
  always_ff @(posedge clk_sys_i or posedge rst_n_i) begin
    if (rst_n_i) begin
      state_r   <= S_IDLE;
      src_cyc_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (head_valid_s & ~head_eof_s) begin
            state_r   <= S_STREAM;
            src_cyc_r <= 1'b1;
          end else begin
            state_r   <= S_IDLE;
            src_cyc_r <= 1'b0;
          end
        end
        S_STREAM: begin
`ifdef WBP_RX_BUFFER_ERR_EN
          if (src_err_i) begin
            src_cyc_r <= 1'b0;
            // A marker already at the head is consumed now, so nothing is left
            // to flush.
            state_r   <= (head_valid_s & head_eof_s) ? S_GAP : S_FLUSH;
          end else if (head_valid_s & head_eof_s) begin
            state_r <= S_DRAIN;
          end else begin
            state_r <= S_STREAM;
          end
`else
          if (head_valid_s & head_eof_s) begin
            state_r <= S_DRAIN;
          end else begin
            state_r <= S_STREAM;
          end
`endif
        end
        S_FLUSH: begin
          src_cyc_r <= 1'b0;
          if (head_valid_s & head_eof_s) begin
            state_r <= S_GAP;
          end else begin
            state_r <= S_FLUSH;
          end
        end
        S_DRAIN: begin
          if (outst_next_s == 16'd0) begin
            state_r   <= S_GAP;
            src_cyc_r <= 1'b0;
          end else begin
            state_r <= S_DRAIN;
          end
        end
        S_GAP: begin
          // The one low cycle has been served. A waiting packet starts at once.
          if (head_valid_s & ~head_eof_s) begin
            state_r   <= S_STREAM;
            src_cyc_r <= 1'b1;
          end else begin
            state_r   <= S_IDLE;
            src_cyc_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= S_IDLE;
          src_cyc_r <= 1'b0;
        end
      endcase
    end
  end

`ifndef WBP_RX_BUFFER_ERR_EN
  logic err_unused_s;
  assign err_unused_s = src_err_i;
`endif

  assign snk_ack_o   = ack_r;
  assign snk_err_o   = 1'b0;
  assign snk_stall_o = stall_r;
  assign src_cyc_o   = src_cyc_r;
  assign src_stb_o   = stb_s;
  assign src_adr_o   = stb_s ? head_s[19:18] : 2'b00;
  assign src_sel_o   = stb_s ? head_s[17:16] : 2'b00;
  assign src_dat_o   = stb_s ? head_s[15:0]  : 16'h0000;
  assign src_we_o    = 1'b1;
  assign usedw_o     = usedw_r;

endmodule
